impulse_line_packer: RTL and testbench
======================================

Name: impulse_line_packer

Overview:
Captures a fixed-length impulse response from the incoming 16-bit audio sample stream and packs it into 1024-bit lines of 64 samples each. It writes those lines sequentially into the impulse memory port that feeds convolve_audio. It raises impulse_in_memory_complete once the whole response is stored. It sits directly upstream of convolve_audio in the audio_clk domain.

Parameters:
IMPULSE_LENGTH, 48000, number of samples captured per run (must be >= 1).
SAMPLES_PER_LINE, 64, samples per memory line; fixed at 64 (line width 1024).
ONSET_THRESHOLD, 16'd2048, magnitude threshold for onset detection (used only with ONSET_TRIGGER_EN).

Ports:
audio_clk  input  1  system audio-domain clock; all logic on rising edge.
rst_in  input  1  asynchronous, active-high reset.
capture_start  input  1  one-cycle pulse that begins (or restarts) a capture.
audio_trigger  input  1  sample-valid strobe, one cycle per sample.
audio_in  input  16  signed sample, valid when audio_trigger=1.
ir_write_addr  output  16  line address in impulse memory.
ir_write_data  output  1024  packed line; sample k of the line occupies bits [16k+15:16k].
ir_write_enable  output  1  one-cycle write strobe.
impulse_in_memory_complete  output  1  high once all lines are written.
busy  output  1  high in ARMED, CAPTURING or FLUSH.
samples_captured  output  16  count of samples accepted in the current run.

Behaviour:
- Reset (async, rst_in=1) clears all outputs and internal state to 0 and forces state IDLE. The lane buffer is cleared. Reset mid-capture discards the partial data and issues no write.
- States: IDLE, ARMED, CAPTURING, FLUSH, DONE.
- IDLE/DONE -> ARMED on capture_start. Entering ARMED clears impulse_in_memory_complete, samples_captured, the line index and the lane buffer.
- ARMED -> CAPTURING on the next cycle; no sample is consumed in ARMED. With ONSET_TRIGGER_EN defined, the state instead stays in ARMED (see Optional Feature).
- CAPTURING, each audio_trigger:
  - audio_in is stored in lane samples_captured[5:0]. Lane 0 is the earliest sample in the line.
  - samples_captured increments.
  - When lane 63 is filled, the full line is snapshotted into ir_write_data. On the next cycle ir_write_enable=1 for exactly one cycle, with ir_write_addr equal to the current line index. The line index then increments.
  - The lane buffer is cleared in the same cycle as the snapshot, so an audio_trigger arriving in the write cycle goes into lane 0 of the next line with no loss.
- When samples_captured reaches IMPULSE_LENGTH:
  - Further audio_trigger pulses are ignored.
  - If IMPULSE_LENGTH mod 64 != 0: go to FLUSH. Unfilled lanes are zero. The partial line is written one cycle later, same strobe rules, then go to DONE.
  - Otherwise go to DONE after the final full-line write.
- DONE: impulse_in_memory_complete=1 and held; busy=0.
- The final write and impulse_in_memory_complete assertion are ordered: complete rises on the cycle after the last ir_write_enable.
- Line count = ceil(IMPULSE_LENGTH/64); the default gives 750 lines, addresses 0..749.
- capture_start in any non-IDLE state restarts: go to ARMED, clear everything, drop any pending write. Write-then-restart on the same cycle: the restart wins and no write is issued.
- ir_write_data and ir_write_addr hold their last values between strobes.

Optional Feature:
ONSET_TRIGGER_EN:
- Defined: ARMED stays armed and discards samples until an audio_trigger arrives with |audio_in| >= ONSET_THRESHOLD. That sample is stored as sample 0 and the state moves to CAPTURING. |−32768| is treated as 32768.
- Undefined: ARMED moves to CAPTURING unconditionally after one cycle, and the first sample after that is stored as sample 0.

Test Plan:
- IMPULSE_LENGTH=128: capture_start, then samples 1..128 -> two writes, at addr 0 (lane0=1, lane63=64) and addr 1 (lane0=65, lane63=128); complete=1 one cycle after the second write.
- IMPULSE_LENGTH=100, samples 1..100 -> write at addr 1 with lanes 0..35 = 65..100 and lanes 36..63 = 0; exactly 2 writes total.
- Back-to-back audio_trigger on every cycle across a line boundary -> sample 65 lands in lane 0 of line 1; none dropped; samples_captured=100 at end.
- Assert rst_in asynchronously after 70 samples -> all outputs 0 immediately; after a fresh capture_start, the first write is at addr 0.
- capture_start issued in DONE, and again mid-capture at sample 40 -> complete drops; restart writes begin at addr 0 with the new data.
- ONSET_TRIGGER_EN, threshold 2048: samples 100, −500, −3000, 7 -> −3000 is stored as lane 0 and 7 as lane 1.

Source files
------------

// File: rtl/impulse_line_packer.sv
// Captures IMPULSE_LENGTH audio samples and packs them into 64-sample, 1024-bit memory lines.
// Optional ONSET_TRIGGER_EN: hold in ARMED until |sample| >= ONSET_THRESHOLD, storing that sample first.
module impulse_line_packer #(
    parameter int          IMPULSE_LENGTH   = 48000,
    parameter int          SAMPLES_PER_LINE = 64,
    parameter logic [15:0] ONSET_THRESHOLD  = 16'd2048
) (
    input  logic          audio_clk,
    input  logic          rst_in,
    input  logic          capture_start,
    input  logic          audio_trigger,
    input  logic [15:0]   audio_in,
    output logic [15:0]   ir_write_addr,
    output logic [1023:0] ir_write_data,
    output logic          ir_write_enable,
    output logic          impulse_in_memory_complete,
    output logic          busy,
    output logic [15:0]   samples_captured
);
    typedef enum logic [2:0] {IDLE, ARMED, CAPTURING, FLUSH, DONE} state_t;

    localparam logic [15:0] LAST_CNT = 16'(IMPULSE_LENGTH - 1);
    localparam logic [5:0]  LAST_LANE = 6'(SAMPLES_PER_LINE - 1);
    localparam bit          PARTIAL  = (IMPULSE_LENGTH % SAMPLES_PER_LINE) != 0;

    state_t state_q, state_d;
    logic [SAMPLES_PER_LINE-1:0][15:0] lanes, line_next;
    logic [15:0] line_idx;
    logic        wr_q;
    logic        accept;
    logic        last_sample;
    logic [5:0]  lane;

    assign lane        = samples_captured[5:0];
    assign last_sample = (samples_captured == LAST_CNT);

`ifdef ONSET_TRIGGER_EN
    logic [16:0] mag;
    logic        onset_hit;
    // 17-bit magnitude so that -32768 maps to +32768
    assign mag       = audio_in[15] ? (17'd0 - {1'b1, audio_in}) : {1'b0, audio_in};
    assign onset_hit = (mag >= {1'b0, ONSET_THRESHOLD});
`else
    logic onset_unused;
    assign onset_unused = ^ONSET_THRESHOLD;
`endif

    always_ff @(posedge audio_clk or posedge rst_in) begin
        if (rst_in) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: ;
            ARMED: begin
`ifdef ONSET_TRIGGER_EN
                if (audio_trigger && onset_hit) begin
                    accept  = 1'b1;
                    state_d = CAPTURING;
                end
`else
                state_d = CAPTURING;
`endif
            end
            CAPTURING: if (audio_trigger) accept = 1'b1;
            FLUSH:     state_d = DONE;
            DONE: ;
            default:   state_d = IDLE;
        endcase
        if (accept && last_sample) state_d = PARTIAL ? FLUSH : DONE;
        // A restart overrides everything, including a line that would complete this cycle
        if (capture_start) begin
            state_d = ARMED;
            accept  = 1'b0;
        end
    end

    always_comb begin
        line_next       = lanes;
        line_next[lane] = audio_in;
    end

    always_ff @(posedge audio_clk or posedge rst_in) begin
        if (rst_in) begin
            lanes                      <= '0;
            line_idx                   <= '0;
            samples_captured           <= '0;
            ir_write_addr              <= '0;
            ir_write_data              <= '0;
            wr_q                       <= 1'b0;
            impulse_in_memory_complete <= 1'b0;
        end else begin
            wr_q <= 1'b0;
            if (capture_start) begin
                lanes                      <= '0;
                line_idx                   <= '0;
                samples_captured           <= '0;
                impulse_in_memory_complete <= 1'b0;
            end else begin
                if (accept) begin
                    samples_captured <= samples_captured + 16'd1;
                    if (lane == LAST_LANE) begin
                        ir_write_data <= line_next;
                        ir_write_addr <= line_idx;
                        line_idx      <= line_idx + 16'd1;
                        wr_q          <= 1'b1;
                        lanes         <= '0;
                    end else begin
                        lanes <= line_next;
                    end
                end
                // Unfilled lanes are already zero since the buffer clears on every snapshot
                if (state_q == FLUSH) begin
                    ir_write_data <= lanes;
                    ir_write_addr <= line_idx;
                    line_idx      <= line_idx + 16'd1;
                    wr_q          <= 1'b1;
                    lanes         <= '0;
                end
                if (state_q == DONE) impulse_in_memory_complete <= 1'b1;
            end
        end
    end

    assign ir_write_enable = wr_q && !capture_start;
    assign busy = (state_q == ARMED) || (state_q == CAPTURING) || (state_q == FLUSH);
endmodule

// File: tb/tb_impulse_line_packer.sv
// Directed bench: one packer with a partial last line (100 samples), one with full lines only (128).
module tb_impulse_line_packer;
    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          trig = 1'b0;
    logic [15:0]   ain = '0;

    logic [15:0]   addr_a, addr_b, cnt_a, cnt_b;
    logic [1023:0] data_a, data_b;
    logic          en_a, en_b, cmp_a, cmp_b, busy_a, busy_b;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    impulse_line_packer #(.IMPULSE_LENGTH(100)) dut (
        .audio_clk(clk), .rst_in(rst), .capture_start(start), .audio_trigger(trig),
        .audio_in(ain), .ir_write_addr(addr_a), .ir_write_data(data_a),
        .ir_write_enable(en_a), .impulse_in_memory_complete(cmp_a), .busy(busy_a),
        .samples_captured(cnt_a));

    impulse_line_packer #(.IMPULSE_LENGTH(128)) dut_full (
        .audio_clk(clk), .rst_in(rst), .capture_start(start), .audio_trigger(trig),
        .audio_in(ain), .ir_write_addr(addr_b), .ir_write_data(data_b),
        .ir_write_enable(en_b), .impulse_in_memory_complete(cmp_b), .busy(busy_b),
        .samples_captured(cnt_b));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // write log per instance, sampled mid-cycle
    logic [15:0]   wa_a[$], wa_b[$];
    logic [1023:0] wd_a[$], wd_b[$];
    int last_wr_a = -100, last_wr_b = -100, rise_a = -1, rise_b = -1;
    logic prev_a = 1'b0, prev_b = 1'b0;

    always @(negedge clk) begin
        if (en_a) begin wa_a.push_back(addr_a); wd_a.push_back(data_a); last_wr_a = cyc; end
        if (en_b) begin wa_b.push_back(addr_b); wd_b.push_back(data_b); last_wr_b = cyc; end
        if (cmp_a && !prev_a) rise_a = cyc;
        if (cmp_b && !prev_b) rise_b = cyc;
        prev_a = cmp_a;
        prev_b = cmp_b;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_line(input string tag, input logic [1023:0] got, input logic [1023:0] exp);
        for (int c = 0; c < 16; c++)
            chk($sformatf("%s[%0d]", tag, c), got[64*c +: 64], exp[64*c +: 64]);
    endtask

    function automatic logic [1023:0] exp_line(input int first, input int count);
        logic [1023:0] r;
        r = '0;
        for (int k = 0; k < 64; k++)
            if (k < count) r[16*k +: 16] = 16'(first + k);
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic kick();
        start = 1'b1;
        step();
        start = 1'b0;
        step();
    endtask

    task automatic feed(input int first, input int n);
        for (int i = 0; i < n; i++) begin
            trig = 1'b1;
            ain  = 16'(first + i);
            step();
        end
        trig = 1'b0;
    endtask

    task automatic clr_log();
        wa_a.delete(); wd_a.delete(); wa_b.delete(); wd_b.delete();
    endtask

    initial begin
        step(); step();
        rst = 1'b0;
        step();
        chk("rst_cnt", 64'(cnt_a), 0);
        chk("rst_busy", 64'(busy_a), 0);
        chk("rst_cmp", 64'(cmp_a), 0);
        chk("rst_en", 64'(en_a), 0);
        chk("rst_addr", 64'(addr_a), 0);
        chk("rst_data", data_a[63:0], 0);

        // full run: 128 samples back-to-back feed both instances
        clr_log();
        kick();
        chk("armed_busy", 64'(busy_a), 1);
        feed(1, 128);
        repeat (3) step();
        chk("a_nwr", 64'(wa_a.size()), 2);
        chk("a_addr0", (wa_a.size() > 0) ? 64'(wa_a[0]) : 64'hdead, 0);
        chk_line("a_line0", (wd_a.size() > 0) ? wd_a[0] : '1, exp_line(1, 64));
        chk("a_addr1", (wa_a.size() > 1) ? 64'(wa_a[1]) : 64'hdead, 1);
        chk("a_l1_lane0", (wd_a.size() > 1) ? 64'(wd_a[1][15:0]) : 64'hdead, 65);
        chk_line("a_line1", (wd_a.size() > 1) ? wd_a[1] : '1, exp_line(65, 36));
        chk("a_cnt", 64'(cnt_a), 100);
        chk("a_cmp", 64'(cmp_a), 1);
        chk("a_busy_done", 64'(busy_a), 0);
        chk("a_cmp_lag", 64'(rise_a - last_wr_a), 1);
        chk("b_nwr", 64'(wa_b.size()), 2);
        chk("b_addr1", (wa_b.size() > 1) ? 64'(wa_b[1]) : 64'hdead, 1);
        chk_line("b_line1", (wd_b.size() > 1) ? wd_b[1] : '1, exp_line(65, 64));
        chk("b_cnt", 64'(cnt_b), 128);
        chk("b_cmp", 64'(cmp_b), 1);
        chk("b_cmp_lag", 64'(rise_b - last_wr_b), 1);

        // restart from DONE, then again mid-capture at sample 40
        clr_log();
        kick();
        chk("rs_cmp_a", 64'(cmp_a), 0);
        chk("rs_cmp_b", 64'(cmp_b), 0);
        chk("rs_cnt", 64'(cnt_a), 0);
        feed(1000, 40);
        kick();
        chk("rs2_cnt", 64'(cnt_a), 0);
        feed(2001, 100);
        repeat (3) step();
        chk("rs_nwr", 64'(wa_a.size()), 2);
        chk("rs_addr0", (wa_a.size() > 0) ? 64'(wa_a[0]) : 64'hdead, 0);
        chk_line("rs_line0", (wd_a.size() > 0) ? wd_a[0] : '1, exp_line(2001, 64));
        chk("rs_cnt_end", 64'(cnt_a), 100);

        // asynchronous reset after 70 samples
        clr_log();
        kick();
        feed(1, 70);
        #2 rst = 1'b1;
        #1;
        chk("ar_cnt", 64'(cnt_a), 0);
        chk("ar_busy", 64'(busy_a), 0);
        chk("ar_addr", 64'(addr_a), 0);
        chk("ar_data", data_a[63:0], 0);
        chk("ar_en", 64'(en_a), 0);
        step();
        rst = 1'b0;
        clr_log();
        kick();
        feed(3001, 64);
        repeat (2) step();
        chk("ar_nwr", 64'(wa_a.size()), 1);
        chk("ar_addr0", (wa_a.size() > 0) ? 64'(wa_a[0]) : 64'hdead, 0);
        chk_line("ar_line0", (wd_a.size() > 0) ? wd_a[0] : '1, exp_line(3001, 64));

        // restart on the same cycle as the 64th sample: no write
        kick();
        clr_log();
        feed(1, 63);
        trig = 1'b1;
        ain = 16'd64;
        start = 1'b1;
        step();
        trig = 1'b0;
        start = 1'b0;
        repeat (3) step();
        chk("wr_rs_nwr", 64'(wa_a.size()), 0);
        chk("wr_rs_cnt", 64'(cnt_a), 0);
        chk("wr_rs_busy", 64'(busy_a), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
